// File: rtl/alu_if.sv
// Operand/result bundle between the accumulator datapath and the ALU.
interface alu_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] accum;
  logic [WIDTH-1:0] data;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] out;
  logic             zero;

  modport master (
    output accum,
    output data,
    output opcode,
    input  out,
    input  zero
  );

  modport slave (
    input  accum,
    input  data,
    input  opcode,
    output out,
    output zero
  );
endinterface

// File: rtl/alu.sv
// Accumulator ALU: opcode-selected result registered on the falling clock edge,
// plus a combinational accumulator-zero flag for skip decisions.
package ex_type_pkg;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_e;
endpackage

module alu #(
  parameter int WIDTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);
  import ex_type_pkg::*;

  logic [WIDTH-1:0] result_s;
  logic [WIDTH-1:0] out_r;

  // Result select; unknown or pass-through opcodes fall back to the accumulator.
  always_comb begin
    result_s = bus.accum;
    case (bus.opcode)
      HLT:     result_s = bus.accum;
      SKZ:     result_s = bus.accum;
      ADD:     result_s = bus.accum + bus.data;
      AND:     result_s = bus.accum & bus.data;
      XOR:     result_s = bus.accum ^ bus.data;
      LDA:     result_s = bus.data;
      STO:     result_s = bus.accum;
      JMP:     result_s = bus.accum;
      default: result_s = bus.accum;
    endcase
  end

  // Output register, loaded on the falling edge so the result is ready by the next rising edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      out_r <= {WIDTH{1'b0}};
    end else begin
      out_r <= result_s;
    end
  end

  assign bus.out  = out_r;
  assign bus.zero = (bus.accum == {WIDTH{1'b0}});
endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a monitor pops and compares.
module tb_alu;
  import ex_type_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_if #(.WIDTH(W)) bus ();

  alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         zero;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference behaviour written from the opcode table with plain integer arithmetic.
  function automatic logic [W-1:0] ref_result(input logic [2:0] op, input int a, input int d);
    int r;
    r = a;
    if (op === 3'd2)      r = (a + d) % 256;
    else if (op === 3'd3) r = a & d;
    else if (op === 3'd4) r = a ^ d;
    else if (op === 3'd5) r = d;
    else                  r = a;
    return r[W-1:0];
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic apply(input logic r, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] d, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    bus.opcode = op;
    bus.accum  = a;
    bus.data   = d;
    e.out  = r ? 8'h00 : ref_result(op, int'(a), int'(d));
    e.zero = (a == 8'h00);
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: the output for inputs driven after one rising edge is due at the next one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".out"}, bus.out, e.out);
        check({e.name, ".zero"}, {7'd0, bus.zero}, {7'd0, e.zero});
      end
    end
  end

  initial begin
    logic [2:0] xop;
    logic [2:0] rop;
    logic [W-1:0] ra;
    logic [W-1:0] rd;
    logic rr;
    bus.opcode = 3'd0;
    bus.accum  = 8'h00;
    bus.data   = 8'h00;

    apply(1'b1, ADD, 8'hDA, 8'h37, "reset0");
    apply(1'b1, ADD, 8'hDA, 8'h37, "reset1");
    apply(1'b0, ADD, 8'hDA, 8'h37, "post_reset_add");

    apply(1'b0, HLT, 8'hDA, 8'h37, "hlt");
    apply(1'b0, SKZ, 8'hDA, 8'h37, "skz");
    apply(1'b0, STO, 8'hDA, 8'h37, "sto");
    apply(1'b0, JMP, 8'hDA, 8'h37, "jmp");
    apply(1'b0, JMP, 8'h00, 8'h37, "jmp_zero");

    apply(1'b0, ADD, 8'hDA, 8'h37, "add_wrap");
    apply(1'b0, AND, 8'hDA, 8'h37, "and1");
    apply(1'b0, XOR, 8'hDA, 8'h37, "xor1");
    apply(1'b0, LDA, 8'hDA, 8'h37, "lda1");

    apply(1'b0, ADD, 8'h12, 8'h07, "add2");
    apply(1'b0, AND, 8'h35, 8'h1F, "and2");
    apply(1'b0, XOR, 8'h1D, 8'h1E, "xor2");
    apply(1'b0, STO, 8'h10, 8'h55, "sto2");

    apply(1'b0, LDA, 8'h00, 8'h72, "lda_zero");
    apply(1'b0, HLT, 8'h01, 8'h72, "accum_change");
    #1;
    check("zero_comb", {7'd0, bus.zero}, 8'h00);
    check("out_hold", bus.out, 8'h72);

    apply(1'b0, ADD, 8'hFF, 8'h01, "add_ff_01");
    apply(1'b0, ADD, 8'hFF, 8'hFF, "add_ff_ff");
    xop = 3'bxxx;
    apply(1'b0, xop, 8'h5C, 8'hA3, "opcode_x");

    apply(1'b0, XOR, 8'h3C, 8'hC3, "pre_reset");
    apply(1'b1, LDA, 8'h3C, 8'h99, "mid_reset");
    apply(1'b0, LDA, 8'h3C, 8'h99, "after_reset");

    for (int i = 0; i < 300; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rd  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 8'h00;
      rr  = ($urandom_range(0, 15) == 0);
      apply(rr, rop, ra, rd, "random");
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
